addsub_seq: RTL



---
 rtl/addsub_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor with Y86
// condition codes (cf[0] ZF, cf[1] SF, cf[2] OF). The WIDTH-bit result is
// built one CHUNK-bit slice per cycle, LSB first, with the carry held in a
// register between slices. Operands arrive via valid/ready and the result
// is held until the consumer accepts it.
// Optional feature: define ADDSUB_SUB_EN to build the subtract path; when
// it is undefined the sub input is ignored and every operation is a + b.
`timescale 1ns/1ps

module addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       cf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             zacc_q;
  logic [2:0]       cf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             subEff;
  logic [WIDTH-1:0] bOperand;

  int               sliceBase;
  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic [CHUNK:0]   sliceSumW;
  logic [CHUNK-1:0] sliceSum;
  logic             sliceZero;
  logic             msbCarryIn;
  logic             lastSlice;
  logic             carry_d;
  logic             zacc_d;
  logic [2:0]       cf_d;

`ifdef ADDSUB_SUB_EN
  assign subEff = sub;
`else
  logic unusedSub;
  assign unusedSub = sub;
  assign subEff    = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b here, the +1 enters as carry-in.
  assign bOperand = subEff ? ~b : b;

  // Slice adder for the current index plus the flag terms of the top slice.
  always_comb begin
    sliceBase  = int'(idx_q) * CHUNK;
    sliceA     = a_q[sliceBase +: CHUNK];
    sliceB     = b_q[sliceBase +: CHUNK];
    sliceSumW  = {1'b0, sliceA} + {1'b0, sliceB} + (CHUNK+1)'(carry_q);
    sliceSum   = sliceSumW[CHUNK-1:0];
    carry_d    = sliceSumW[CHUNK];
    sliceZero  = (sliceSum == '0);
    zacc_d     = zacc_q & sliceZero;
    msbCarryIn = sliceA[CHUNK-1] ^ sliceB[CHUNK-1] ^ sliceSum[CHUNK-1];
    lastSlice  = (idx_q == LAST_IDX);
    cf_d       = {msbCarryIn ^ carry_d, sliceSum[CHUNK-1], zacc_d};
  end

  // Control FSM with operand capture, slice accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      zacc_q      <= 1'b0;
      cf_q        <= 3'b000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= bOperand;
            carry_q    <= subEff;
            idx_q      <= '0;
            zacc_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          out_q[sliceBase +: CHUNK] <= sliceSum;
          carry_q <= carry_d;
          zacc_q  <= zacc_d;
          if (lastSlice) begin
            idx_q       <= '0;
            cf_q        <= cf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cf        = cf_q;

endmodule
